stream_burst_source: RTL and testbench
======================================

STREAM_BURST_SOURCE -- requirements
Module: stream_burst_source

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, beat data width.
REQ-002 SHALL have parameter LEN_WIDTH, default 8, burst-length field width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a new burst; sampled only in IDLE.
REQ-006 SHALL have port start_value  input  DATA_WIDTH  first beat data, captured on accepted start.
REQ-007 SHALL have port step  input  DATA_WIDTH  per-beat increment, captured on accepted start.
REQ-008 SHALL have port burst_len  input  LEN_WIDTH  number of beats, captured on accepted start.
REQ-009 SHALL have port pause  input  1  inhibits presenting the next beat.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  beat payload, registered.
REQ-011 SHALL have port out_valid  output  1  beat present, registered.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the beat.
REQ-013 SHALL have port busy  output  1  high from accepted start until done.
REQ-014 SHALL have port done  output  1  one-cycle pulse at burst end.

Function
REQ-015 SHALL treat a beat as transferred on a rising edge with out_valid=1 and out_ready=1.
REQ-016 SHALL implement FSM states IDLE, SEND, FINISH.
- IDLE -> SEND on start=1 with burst_len!=0.
- IDLE -> FINISH on start=1 with burst_len=0.
- SEND -> FINISH on transfer of the last beat.
- FINISH -> IDLE unconditionally.
REQ-017 SHALL raise out_valid in the cycle after an accepted start (latency 1) with out_data=start_value, unless pause=1 at that edge.
REQ-018 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0; out_valid is never retracted before transfer.
REQ-019 SHALL, on a non-final transfer with pause=0, present the next beat in the following cycle with no bubble, data = previous + step modulo 2^DATA_WIDTH (wrap-around, carry discarded).
REQ-020 SHALL, on a transfer with pause=1, drive out_valid=0 next cycle and resume the pending beat on the first edge where pause=0; pause never affects an already-presented beat.
REQ-021 SHALL drive out_valid=0 in FINISH and IDLE; exactly burst_len beats per burst.
REQ-022 SHALL assert done for exactly the FINISH cycle and busy in SEND and FINISH.
REQ-023 SHALL ignore start while busy=1; a start sampled in the FINISH cycle is dropped.
REQ-024 SHALL ignore changes on start_value, step, burst_len after capture.
REQ-025 SHALL accept burst_len of 2^LEN_WIDTH-1 without counter overflow.

Reset
REQ-026 SHALL, while reset=1, force state IDLE, out_valid=0, out_data=0, busy=0, done=0, internal counters 0.
REQ-027 SHALL abort any in-flight burst on reset; no done pulse is produced for it; reset has priority over start.

Structure
REQ-028 SHALL place the FSM state enum typedef in shared package stream_pkg.
REQ-029 SHALL be a single module with no sub-modules; beat counter and data accumulator inline.

Verification
REQ-030 start_value=0x15, step=1, burst_len=3, out_ready=1 -> out_data 0x15,0x16,0x17 on consecutive cycles, done pulse the cycle after 0x17 transfers.
REQ-031 burst_len=2, start_value=0x3C, out_ready=0 for 3 cycles then 1 -> 0x3C held stable 4 cycles, then 0x3D, then done.
REQ-032 start_value=0xFE, step=0x01, burst_len=3 -> 0xFE,0xFF,0x00 (wrap).
REQ-033 burst_len=0 -> no out_valid, busy and done high one cycle after start.
REQ-034 burst_len=4, pause=1 after 2nd transfer for 2 cycles -> out_valid low 2 cycles, beats 3 and 4 follow in order, start pulses during the burst ignored.
REQ-035 reset=1 mid-burst after 1 of 4 beats -> out_valid=0 and busy=0 next cycle, no done; new burst after reset starts from its own start_value.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared types for the stream burst source.
// Holds the burst FSM state encoding.
package stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

endpackage

// File: rtl/stream_burst_source.sv
// Arithmetic-progression burst generator on a valid/ready stream.
// Beat counter and data accumulator live inline with the FSM.
module stream_burst_source
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] start_value,
    input  logic [DATA_WIDTH-1:0] step,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic                  pause,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    state_e                  state_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH-1:0]   data_d;
    logic [DATA_WIDTH-1:0]   step_q;
    logic [LEN_WIDTH-1:0]    left_q;
    logic                    valid_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    xfer;

    assign xfer   = valid_q & out_ready;
    // Carry out of the add is dropped so the sequence wraps.
    assign data_d = data_q + step_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            step_q  <= '0;
            left_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        data_q <= start_value;
                        step_q <= step;
                        left_q <= burst_len;
                        busy_q <= 1'b1;
                        if (burst_len == '0) begin
                            state_q <= ST_FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_SEND;
                            valid_q <= ~pause;
                        end
                    end
                end
                ST_SEND: begin
                    if (xfer) begin
                        if (left_q == LEN_ONE) begin
                            state_q <= ST_FINISH;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            left_q  <= '0;
                        end else begin
                            left_q  <= left_q - LEN_ONE;
                            data_q  <= data_d;
                            valid_q <= ~pause;
                        end
                    end else if (!valid_q && !pause) begin
                        // Pending beat waited out a pause.
                        valid_q <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_stream_burst_source.sv
// Scoreboard bench for stream_burst_source.
// Directed bursts; a negedge monitor checks every transferred beat.
module tb_stream_burst_source;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] start_value;
    logic [7:0] step;
    logic [7:0] burst_len;
    logic       pause;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];

    logic       hold_pend = 1'b0;
    logic [7:0] hold_data = '0;

    always #5 clk = ~clk;

    stream_burst_source #(
        .DATA_WIDTH(8),
        .LEN_WIDTH (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_value(start_value),
        .step       (step),
        .burst_len  (burst_len),
        .pause      (pause),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name, input int exp_cycles);
        int n = 0;
        while (!done && n < 1000) begin
            tick();
            n++;
        end
        chk(name, n, exp_cycles);
    endtask

    // Monitor: scoreboard pop on each transfer plus stall stability.
    always @(negedge clk) begin
        logic [7:0] e;
        if (hold_pend && !reset) begin
            checks++;
            if (!out_valid || out_data !== hold_data) begin
                errors++;
                $display("FAIL hold valid=%0b data=%0h expected valid=1 data=%0h",
                         out_valid, out_data, hold_data);
            end
        end
        hold_pend = out_valid && !out_ready && !reset;
        hold_data = out_data;
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected actual=%0h expected=none", out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL beat actual=%0h expected=%0h", out_data, e);
                end
            end
        end
        if (done) done_cnt++;
    end

    task automatic launch(input logic [7:0] sv, input logic [7:0] st,
                          input logic [7:0] len);
        start       = 1'b1;
        start_value = sv;
        step        = st;
        burst_len   = len;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start_value = '0; step = '0;
        burst_len = '0; pause = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        tick();

        // Basic 3-beat burst, then a start dropped in FINISH.
        out_ready = 1'b1;
        exp_q.push_back(8'h15); exp_q.push_back(8'h16); exp_q.push_back(8'h17);
        launch(8'h15, 8'h01, 8'd3);
        chk("b1_valid", out_valid, 1);
        chk("b1_first", out_data, 8'h15);
        chk("b1_busy", busy, 1);
        wait_done("b1_done_lat", 3);
        chk("b1_fin_busy", busy, 1);
        chk("b1_fin_valid", out_valid, 0);
        start = 1'b1; burst_len = 8'd1; start_value = 8'hEE;
        tick();
        start = 1'b0;
        chk("fin_drop_busy", busy, 0);
        chk("fin_drop_done", done, 0);
        tick();
        chk("fin_drop_busy2", busy, 0);
        chk("fin_drop_valid", out_valid, 0);

        // Backpressure: first beat held 4 cycles.
        out_ready = 1'b0;
        exp_q.push_back(8'h3C); exp_q.push_back(8'h3D);
        launch(8'h3C, 8'h01, 8'd2);
        repeat (3) begin
            chk("b2_stall_valid", out_valid, 1);
            chk("b2_stall_data", out_data, 8'h3C);
            tick();
        end
        out_ready = 1'b1;
        wait_done("b2_done_lat", 2);
        tick();

        // Wrap-around; inputs scrambled after capture.
        exp_q.push_back(8'hFE); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
        launch(8'hFE, 8'h01, 8'd3);
        start_value = 8'h00; step = 8'h10; burst_len = 8'd1;
        wait_done("b3_done_lat", 3);
        tick();

        // Zero-length burst.
        launch(8'h55, 8'h01, 8'd0);
        chk("b4_valid", out_valid, 0);
        chk("b4_busy", busy, 1);
        chk("b4_done", done, 1);
        tick();
        chk("b4_busy_after", busy, 0);
        chk("b4_done_after", done, 0);

        // Pause after 2nd transfer, with ignored starts.
        exp_q.push_back(8'h40); exp_q.push_back(8'h43);
        exp_q.push_back(8'h46); exp_q.push_back(8'h49);
        launch(8'h40, 8'h03, 8'd4);
        chk("b5_first", out_data, 8'h40);
        start = 1'b1; start_value = 8'hAA; burst_len = 8'd9;
        tick();
        start = 1'b0; pause = 1'b1;
        chk("b5_beat2_valid", out_valid, 1);
        tick();
        chk("b5_pause1", out_valid, 0);
        tick();
        chk("b5_pause2", out_valid, 0);
        pause = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b5_resume", out_valid, 1);
        chk("b5_resume_data", out_data, 8'h46);
        wait_done("b5_done_lat", 2);
        tick();
        chk("b5_idle_busy", busy, 0);
        chk("b5_idle_valid", out_valid, 0);

        // Maximum length burst.
        for (int i = 0; i < 255; i++) exp_q.push_back(8'(i));
        launch(8'h00, 8'h01, 8'd255);
        wait_done("b6_done_lat", 255);
        tick();

        // Reset mid-burst, reset beats start, then a fresh burst.
        exp_q.push_back(8'h10);
        launch(8'h10, 8'h01, 8'd4);
        tick();
        reset = 1'b1; start = 1'b1; start_value = 8'h99; burst_len = 8'd2;
        tick();
        chk("b7_rst_valid", out_valid, 0);
        chk("b7_rst_busy", busy, 0);
        chk("b7_rst_done", done, 0);
        chk("b7_rst_data", out_data, 0);
        reset = 1'b0; start = 1'b0;
        exp_q.push_back(8'h77);
        launch(8'h77, 8'h05, 8'd1);
        chk("b7_new_data", out_data, 8'h77);
        wait_done("b7_done_lat", 1);
        tick(); tick();

        chk("done_total", done_cnt, 7);
        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
